// File: rtl/captura_ctrl_pkg.sv
// captura_pkg: shared types and constants for the keypad setpoint sequencer.
//   estado_t        : FSM state encoding (3 bits, also exported as debug output)
//   DIG_MAX/BIN_MAX : highest key accepted for decimal and binary fields
//   TEMP_MAX_DEF    : default highest accepted setpoint
//   TIMEOUT_CYC_DEF : default idle-cycle budget between digits
package captura_pkg;

   typedef enum logic [2:0] {
      ESP_DEC = 3'd0,
      ESP_UNI = 3'd1,
      ESP_MOT = 3'd2,
      ESP_PRE = 3'd3,
      ENTREGA = 3'd4,
      FALLO   = 3'd5
   } estado_t;

   localparam int unsigned DIG_MAX         = 9;
   localparam int unsigned BIN_MAX         = 1;
   localparam int unsigned TEMP_MAX_DEF    = 80;
   localparam int unsigned TIMEOUT_CYC_DEF = 50000000;

endpackage

// File: rtl/captura_ctrl_if.sv
// captura_ctrl_if: keypad-side and unification-side signals of captura_ctrl.
//   slave  : the sequencer view (keys and listo_uni in, commit/status out)
//   master : the environment view (drives keys and listo_uni)
interface captura_ctrl_if;

   logic       esnumero;
   logic [3:0] tvalida;
   logic       listo_uni;
   logic       enable_FSM1;
   logic [3:0] decenas;
   logic [3:0] unidades;
   logic [3:0] motor;
   logic [3:0] presencia;
   logic       cargar;
   logic       error;
   logic [2:0] estado;

   modport slave (
      input  esnumero, tvalida, listo_uni,
      output enable_FSM1, decenas, unidades, motor, presencia,
             cargar, error, estado
   );

   modport master (
      output esnumero, tvalida, listo_uni,
      input  enable_FSM1, decenas, unidades, motor, presencia,
             cargar, error, estado
   );

endinterface

// File: rtl/captura_ctrl_temporizador.sv
// temporizador_tecla: inter-digit idle counter.
//   i_clk    : clock
//   i_rst    : synchronous active-high reset
//   i_clr    : clear counter to 0 (has priority over i_run)
//   i_run    : count up one per cycle
//   o_expira : counter sits at TIMEOUT_CYC-1 while running
module temporizador_tecla #(
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expira
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         r_cnt <= '0;
      else if (i_run)
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_expira = i_run && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/captura_ctrl.sv
// captura_ctrl: keypad setpoint entry sequencer.
// Collects tens, units, motor and presence keys, range-checks the setpoint
// and commits it to the unification stage with a cargar/listo_uni handshake.
//   CLK, Reset : clock, synchronous active-high reset
//   io_cap     : esnumero/tvalida key strobe, listo_uni ready in;
//                enable_FSM1, committed digits, cargar, error, estado out
module captura_ctrl
   import captura_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned TEMP_MAX    = TEMP_MAX_DEF,
   parameter int unsigned CNT_W       = 26
) (
   input  logic            CLK,
   input  logic            Reset,
   captura_ctrl_if.slave   io_cap
);

   estado_t    r_state;
   estado_t    w_next;
   logic [3:0] r_dec;
   logic [3:0] r_uni;
   logic [3:0] r_mot;
   logic [3:0] r_out_dec;
   logic [3:0] r_out_uni;
   logic [3:0] r_out_mot;
   logic [3:0] r_out_pre;
   logic       w_digito_ok;
   logic       w_espera;
   logic       w_run;
   logic       w_clr;
   logic       w_expira;
   logic [6:0] w_temp;

   // Decimal fields accept 0-9, binary fields accept 0-1.
   always_comb begin
      w_digito_ok = 1'b0;
      case (r_state)
         ESP_DEC, ESP_UNI: w_digito_ok = (io_cap.tvalida <= 4'(DIG_MAX));
         ESP_MOT, ESP_PRE: w_digito_ok = (io_cap.tvalida <= 4'(BIN_MAX));
         default:          w_digito_ok = 1'b0;
      endcase
   end

   assign w_espera = (r_state == ESP_DEC) || (r_state == ESP_UNI) ||
                     (r_state == ESP_MOT) || (r_state == ESP_PRE);
   assign w_run    = (r_state == ESP_UNI) || (r_state == ESP_MOT) ||
                     (r_state == ESP_PRE);
   assign w_temp   = {3'b000, r_dec} * 7'd10 + {3'b000, r_uni};

   // Timer restarts on any accepted key or state change and is parked at 0
   // outside the mid-entry states.
   assign w_clr = (w_espera && io_cap.esnumero) || (w_next != r_state) || !w_run;

   temporizador_tecla #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_temporizador (
      .i_clk    (CLK),
      .i_rst    (Reset),
      .i_clr    (w_clr),
      .i_run    (w_run),
      .o_expira (w_expira)
   );

   always_ff @(posedge CLK) begin
      if (Reset)
         r_state <= ESP_DEC;
      else
         r_state <= w_next;
   end

   // A key in the expiry cycle takes precedence over the timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ESP_DEC: begin
            if (io_cap.esnumero)
               w_next = w_digito_ok ? ESP_UNI : FALLO;
         end
         ESP_UNI: begin
            if (io_cap.esnumero)
               w_next = w_digito_ok ? ESP_MOT : FALLO;
            else if (w_expira)
               w_next = FALLO;
         end
         ESP_MOT: begin
            if (io_cap.esnumero)
               w_next = w_digito_ok ? ESP_PRE : FALLO;
            else if (w_expira)
               w_next = FALLO;
         end
         ESP_PRE: begin
            if (io_cap.esnumero) begin
               if (!w_digito_ok || (w_temp > 7'(TEMP_MAX)))
                  w_next = FALLO;
               else
                  w_next = ENTREGA;
            end else if (w_expira) begin
               w_next = FALLO;
            end
         end
         ENTREGA: begin
            if (io_cap.listo_uni)
               w_next = ESP_DEC;
         end
         FALLO:   w_next = ESP_DEC;
         default: w_next = ESP_DEC;
      endcase
   end

   always_comb begin
      io_cap.enable_FSM1 = (r_state != ENTREGA);
      io_cap.cargar      = (r_state == ENTREGA);
      io_cap.error       = (r_state == FALLO);
      io_cap.estado      = r_state;
   end

   // The presence key is committed straight from tvalida on the same edge it
   // is accepted, so it needs no shadow register of its own.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_dec     <= '0;
         r_uni     <= '0;
         r_mot     <= '0;
         r_out_dec <= '0;
         r_out_uni <= '0;
         r_out_mot <= '0;
         r_out_pre <= '0;
      end else begin
         case (r_state)
            ESP_DEC: if (io_cap.esnumero && w_digito_ok) r_dec <= io_cap.tvalida;
            ESP_UNI: if (io_cap.esnumero && w_digito_ok) r_uni <= io_cap.tvalida;
            ESP_MOT: if (io_cap.esnumero && w_digito_ok) r_mot <= io_cap.tvalida;
            ESP_PRE: begin
               if (w_next == ENTREGA) begin
                  r_out_dec <= r_dec;
                  r_out_uni <= r_uni;
                  r_out_mot <= r_mot;
                  r_out_pre <= io_cap.tvalida;
               end
            end
            ENTREGA: begin
               if (io_cap.listo_uni) begin
                  r_dec <= '0;
                  r_uni <= '0;
                  r_mot <= '0;
               end
            end
            FALLO: begin
               r_dec <= '0;
               r_uni <= '0;
               r_mot <= '0;
            end
            default: ;
         endcase
      end
   end

   assign io_cap.decenas   = r_out_dec;
   assign io_cap.unidades  = r_out_uni;
   assign io_cap.motor     = r_out_mot;
   assign io_cap.presencia = r_out_pre;

endmodule

// File: tb/tb_captura_ctrl.sv
// tb_captura_ctrl: directed self-checking bench for captura_ctrl.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_captura_ctrl;

   logic CLK;
   logic Reset;
   int   pass_cnt;
   int   total_cnt;

   captura_ctrl_if cif ();

   captura_ctrl #(
      .TIMEOUT_CYC (16),
      .TEMP_MAX    (80),
      .CNT_W       (5)
   ) dut (
      .CLK    (CLK),
      .Reset  (Reset),
      .io_cap (cif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Snapshot layout: estado, cargar, error, enable_FSM1, decenas, unidades, motor, presencia
   function automatic logic [21:0] mk(input logic [2:0] st, input logic c, input logic e,
                                      input logic en, input logic [3:0] d, input logic [3:0] u,
                                      input logic [3:0] m, input logic [3:0] p);
      return {st, c, e, en, d, u, m, p};
   endfunction

   function automatic logic [21:0] snap();
      return {cif.estado, cif.cargar, cif.error, cif.enable_FSM1,
              cif.decenas, cif.unidades, cif.motor, cif.presencia};
   endfunction

   // Called at a falling edge: one-cycle key strobe, returns at the next falling edge.
   task automatic press(input logic [3:0] key);
      cif.esnumero = 1'b1;
      cif.tvalida  = key;
      @(negedge CLK);
      cif.esnumero = 1'b0;
   endtask

   task automatic test_reset();
      logic [21:0] exp_v;
      Reset = 1'b1;
      cif.esnumero = 1'b0;
      cif.tvalida = 4'd0;
      cif.listo_uni = 1'b1;
      repeat (3) @(negedge CLK);
      Reset = 1'b0;
      exp_v = mk(3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL reset: got %h want %h", snap(), exp_v);
      else pass_cnt++;
   endtask

   task automatic test_commit();
      logic [21:0] exp_v;
      press(4'd2);
      exp_v = mk(3'd1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL commit_tens: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      press(4'd5);
      press(4'd1);
      exp_v = mk(3'd3, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL commit_motor: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      press(4'd0);
      exp_v = mk(3'd4, 1'b1, 1'b0, 1'b0, 4'd2, 4'd5, 4'd1, 4'd0);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL commit_entrega: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      @(negedge CLK);
      exp_v = mk(3'd0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5, 4'd1, 4'd0);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL commit_return: got %h want %h", snap(), exp_v);
      else pass_cnt++;
   endtask

   task automatic test_range();
      logic [21:0] exp_v;
      press(4'd8); press(4'd5); press(4'd0); press(4'd1);
      exp_v = mk(3'd5, 1'b0, 1'b1, 1'b1, 4'd2, 4'd5, 4'd1, 4'd0);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL range_85: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      @(negedge CLK);
      exp_v = mk(3'd0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5, 4'd1, 4'd0);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL range_85_return: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      press(4'd8); press(4'd0); press(4'd0); press(4'd1);
      exp_v = mk(3'd4, 1'b1, 1'b0, 1'b0, 4'd8, 4'd0, 4'd0, 4'd1);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL range_80: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      @(negedge CLK);
   endtask

   task automatic test_invalid();
      logic [21:0] exp_v;
      press(4'd12);
      exp_v = mk(3'd5, 1'b0, 1'b1, 1'b1, 4'd8, 4'd0, 4'd0, 4'd1);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL invalid_dec: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      @(negedge CLK);
      exp_v = mk(3'd0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 4'd1);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL invalid_dec_return: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      press(4'd1); press(4'd2); press(4'd3);
      exp_v = mk(3'd5, 1'b0, 1'b1, 1'b1, 4'd8, 4'd0, 4'd0, 4'd1);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL invalid_mot: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      @(negedge CLK);
      exp_v = mk(3'd0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 4'd1);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL invalid_mot_return: got %h want %h", snap(), exp_v);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      logic [21:0] exp_v;
      press(4'd4);
      for (int n = 1; n <= 16; n++) begin
         @(negedge CLK);
         if (n == 15) begin
            exp_v = mk(3'd1, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 4'd1);
            total_cnt++;
            if (snap() !== exp_v) $display("FAIL timeout_pre: got %h want %h", snap(), exp_v);
            else pass_cnt++;
         end else if (n == 16) begin
            exp_v = mk(3'd5, 1'b0, 1'b1, 1'b1, 4'd8, 4'd0, 4'd0, 4'd1);
            total_cnt++;
            if (snap() !== exp_v) $display("FAIL timeout_fire: got %h want %h", snap(), exp_v);
            else pass_cnt++;
         end
      end
      @(negedge CLK);
      // Key lands exactly in the expiry cycle: key wins.
      press(4'd4);
      repeat (15) @(negedge CLK);
      press(4'd7);
      exp_v = mk(3'd2, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 4'd1);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL timeout_key_wins: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      press(4'd0); press(4'd1);
      exp_v = mk(3'd4, 1'b1, 1'b0, 1'b0, 4'd4, 4'd7, 4'd0, 4'd1);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL timeout_key_commit: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      logic [21:0] exp_v;
      cif.listo_uni = 1'b0;
      press(4'd3); press(4'd0); press(4'd1); press(4'd1);
      exp_v = mk(3'd4, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd1, 4'd1);
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if (snap() !== exp_v) $display("FAIL hold_cycle%0d: got %h want %h", i, snap(), exp_v);
         else pass_cnt++;
         cif.esnumero = 1'b1;
         cif.tvalida  = 4'(i);
         @(negedge CLK);
      end
      cif.esnumero = 1'b0;
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL hold_after_keys: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      cif.listo_uni = 1'b1;
      @(negedge CLK);
      exp_v = mk(3'd0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd1, 4'd1);
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL hold_release: got %h want %h", snap(), exp_v);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [21:0] exp_v;
      exp_v = mk(3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      press(4'd2); press(4'd2); press(4'd1);
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL reset_in_pre: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      cif.listo_uni = 1'b0;
      press(4'd5); press(4'd5); press(4'd0); press(4'd1);
      total_cnt++;
      if (snap() !== mk(3'd4, 1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 4'd0, 4'd1))
         $display("FAIL reset_setup_entrega: got %h want %h", snap(),
                  mk(3'd4, 1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 4'd0, 4'd1));
      else pass_cnt++;
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      total_cnt++;
      if (snap() !== exp_v) $display("FAIL reset_in_entrega: got %h want %h", snap(), exp_v);
      else pass_cnt++;
      cif.listo_uni = 1'b1;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      Reset = 1'b1;
      cif.esnumero  = 1'b0;
      cif.tvalida   = 4'd0;
      cif.listo_uni = 1'b1;
      @(negedge CLK);
      test_reset();
      test_commit();
      test_range();
      test_invalid();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
